// File: rtl/posit_add_sched_pkg.sv
// Shared types and constants for the posit adder scheduler and later shared units.
package posit_add_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEC,
        ALIGN,
        ADD,
        NORM,
        ENC,
        CAP,
        RESP
    } add_state_t;

    typedef logic [7:0] posit8_t;

    localparam posit8_t POSIT_ZERO = 8'h00;
    localparam posit8_t POSIT_NAR  = 8'h80;

endpackage

// File: rtl/posit_add_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW-1:0] pos;
    int            sum;

    // Scan from the pointer upwards, wrapping at N, and keep the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        sum   = 0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr_i) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            pos = IW'(sum);
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule

// File: rtl/posit_add_sched.sv
// Round-robin front end that time-shares one staged posit adder between requesters.
//
// state | meaning
// IDLE  | waiting for a request; grant offered combinationally
// DEC   | datapath decode stage enabled
// ALIGN | datapath align stage enabled
// ADD   | datapath add stage enabled
// NORM  | datapath normalise stage enabled
// ENC   | datapath encode stage enabled
// CAP   | dp_result is valid; capture it
// RESP  | result presented until the consumer accepts it
module posit_add_sched
    import posit_add_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 7,
    parameter int EN    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*(WIDTH+1)-1:0] req_a,
    input  logic [NREQ*(WIDTH+1)-1:0] req_b,
    output logic [WIDTH:0]            dp_a,
    output logic [WIDTH:0]            dp_b,
    output logic [4:0]                dp_stage_en,
    input  logic [WIDTH:0]            dp_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH:0]            rsp_result,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = WIDTH + 1;
    localparam logic [WIDTH:0] ZERO_W = '0;
    localparam logic [WIDTH:0] NAR_W  = {1'b1, {WIDTH{1'b0}}};

    // es is consumed by the datapath only; reject settings it cannot encode.
    if (NREQ < 2 || EN < 0 || EN > WIDTH - 2) begin : g_bad_cfg
        $error("posit_add_sched: unsupported NREQ/EN configuration");
    end

    add_state_t      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   id_q;
    logic [WIDTH:0]  a_q, b_q, res_q, res_d;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic [WIDTH:0]  a_arr [NREQ];
    logic [WIDTH:0]  b_arr [NREQ];
    logic [WIDTH:0]  a_sel, b_sel, sc_res;
    logic            sc_hit, hs;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*PW +: PW];
        assign b_arr[i] = req_b[i*PW +: PW];
    end

    rr_arbiter #(.N(NREQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign a_sel = a_arr[gnt_idx];
    assign b_sel = b_arr[gnt_idx];

    // Zero/NaR operands bypass the datapath entirely; NaR dominates zero.
    always_comb begin
        sc_hit = (a_sel == NAR_W) || (b_sel == NAR_W) ||
                 (a_sel == ZERO_W) || (b_sel == ZERO_W);
        if ((a_sel == NAR_W) || (b_sel == NAR_W)) begin
            sc_res = NAR_W;
        end else if (a_sel == ZERO_W) begin
            sc_res = b_sel;
        end else begin
            sc_res = a_sel;
        end
    end

    // Next state, grant, stage enables and result capture.
    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        hs          = 1'b0;
        res_d       = res_q;
        rsp_valid   = 1'b0;
        dp_stage_en = '0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so the grant is quiet while held in reset.
                if (rst_n) begin
                    req_ready = gnt;
                end
                hs = |(req_valid & req_ready);
                if (hs) begin
                    if (sc_hit) begin
                        state_d = RESP;
                        res_d   = sc_res;
                    end else begin
                        state_d = DEC;
                    end
                end
            end
            DEC: begin
                dp_stage_en = 5'b00001;
                state_d     = ALIGN;
            end
            ALIGN: begin
                dp_stage_en = 5'b00010;
                state_d     = ADD;
            end
            ADD: begin
                dp_stage_en = 5'b00100;
                state_d     = NORM;
            end
            NORM: begin
                dp_stage_en = 5'b01000;
                state_d     = ENC;
            end
            ENC: begin
                dp_stage_en = 5'b10000;
                state_d     = CAP;
            end
            CAP: begin
                res_d   = dp_result;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin pointer, operand latches and response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            res_q    <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            if (hs) begin
                a_q      <= a_sel;
                b_q      <= b_sel;
                id_q     <= gnt_idx;
                rr_ptr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            end
        end
    end

    assign dp_a       = a_q;
    assign dp_b       = b_q;
    assign rsp_result = res_q;
    assign rsp_id     = id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_posit_add_sched.sv
// Directed bench with a transaction-timeline reference model for posit_add_sched.
module tb_posit_add_sched;
    import posit_add_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  ra [4];
    logic [7:0]  rb [4];
    logic [31:0] req_a, req_b;
    logic [7:0]  dp_a, dp_b;
    logic [4:0]  dp_stage_en;
    logic [7:0]  dp_result = 8'hEE;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_result;
    logic [1:0]  rsp_id;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign req_a = {ra[3], ra[2], ra[1], ra[0]};
    assign req_b = {rb[3], rb[2], rb[1], rb[0]};

    posit_add_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .dp_a        (dp_a),
        .dp_b        (dp_b),
        .dp_stage_en (dp_stage_en),
        .dp_result   (dp_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    // Datapath stub: the chosen sum appears only in the cycle after encode.
    logic [7:0] dp_val = 8'h00;
    logic       enc_seen = 1'b0;
    always @(negedge clk) enc_seen <= dp_stage_en[4];
    always @(posedge clk) dp_result <= enc_seen ? dp_val : 8'hEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pick_idx(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] pick_oh(input logic [3:0] v, input int p);
        int j;
        j = pick_idx(v, p);
        return (j < 0) ? 4'b0000 : (4'b0001 << j);
    endfunction

    function automatic bit is_sc(input logic [7:0] a, input logic [7:0] b);
        return (a == POSIT_NAR) || (b == POSIT_NAR) || (a == POSIT_ZERO) || (b == POSIT_ZERO);
    endfunction

    function automatic logic [7:0] sc_val(input logic [7:0] a, input logic [7:0] b);
        if (a == POSIT_NAR || b == POSIT_NAR) return POSIT_NAR;
        if (a == POSIT_ZERO) return b;
        return a;
    endfunction

    function automatic logic [4:0] exp_stage(input bit bsy, input int lat, input int t);
        if (bsy && lat == 7 && t >= 1 && t <= 5) return 5'b00001 << (t - 1);
        return 5'b00000;
    endfunction

    // m_t counts cycles since the accepting edge; response appears once m_t reaches m_lat.
    bit         m_busy = 1'b0;
    int         m_ptr = 0, m_t = 0, m_lat = 0, m_id = 0;
    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_res = 8'h00;

    // Model advance on each clock edge; cleared by reset like the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_ptr  <= 0;
            m_t    <= 0;
            m_lat  <= 0;
            m_id   <= 0;
            m_a    <= 8'h00;
            m_b    <= 8'h00;
            m_res  <= 8'h00;
        end else if (!m_busy) begin
            if (|req_valid) begin
                m_busy <= 1'b1;
                m_id   <= pick_idx(req_valid, m_ptr);
                m_ptr  <= (pick_idx(req_valid, m_ptr) + 1) % 4;
                m_a    <= ra[pick_idx(req_valid, m_ptr)];
                m_b    <= rb[pick_idx(req_valid, m_ptr)];
                m_t    <= 1;
                if (is_sc(ra[pick_idx(req_valid, m_ptr)], rb[pick_idx(req_valid, m_ptr)])) begin
                    m_lat <= 1;
                    m_res <= sc_val(ra[pick_idx(req_valid, m_ptr)], rb[pick_idx(req_valid, m_ptr)]);
                end else begin
                    m_lat <= 7;
                    m_res <= dp_val;
                end
            end
        end else if (m_t >= m_lat) begin
            if (rsp_ready) m_busy <= 1'b0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_req_ready", req_ready, (!rst_n || m_busy) ? 4'b0000 : pick_oh(req_valid, m_ptr));
        chk("m_busy", busy, m_busy && rst_n);
        chk("m_stage_en", dp_stage_en, rst_n ? exp_stage(m_busy, m_lat, m_t) : 5'b0);
        chk("m_rsp_valid", rsp_valid, rst_n && m_busy && (m_t >= m_lat));
        chk("m_dp_a", dp_a, m_a);
        chk("m_dp_b", dp_b, m_b);
        if (!rst_n || (m_busy && m_t >= m_lat)) begin
            chk("m_rsp_result", rsp_result, m_res);
            chk("m_rsp_id", rsp_id, m_id[1:0]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic sc_txn(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp);
        ra[id] = a;
        rb[id] = b;
        req_valid = 4'b0001 << id;
        @(negedge clk);
        chk("sc_grant", req_ready, 4'b0001 << id);
        chk("sc_stage_idle", dp_stage_en, 5'b0);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("sc_rsp_valid", rsp_valid, 1'b1);
        chk("sc_rsp_result", rsp_result, exp);
        chk("sc_rsp_id", rsp_id, id);
        chk("sc_stage_none", dp_stage_en, 5'b0);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    int glog[$];
    bit seen;

    initial begin
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra[i] = 8'h00;
            rb[i] = 8'h00;
        end
        #1 rst_n = 1'b0;
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_stage", dp_stage_en, 5'b0);
        chk("rst_result", rsp_result, 8'h00);
        chk("rst_id", rsp_id, 2'd0);
        chk("rst_dp_a", dp_a, 8'h00);
        req_valid = 4'b0000;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full path, requester 1, 1.0 + 1.0 = 2.0.
        ra[1] = 8'h40; rb[1] = 8'h40; dp_val = 8'h50;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("full_grant", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("full_stage", dp_stage_en, (k <= 5) ? (5'b00001 << (k - 1)) : 5'b0);
            chk("full_rsp_valid", rsp_valid, k == 7);
        end
        chk("full_result", rsp_result, 8'h50);
        chk("full_id", rsp_id, 2'd1);
        chk("full_dp_a", dp_a, 8'h40);
        @(posedge clk); #1;

        // Short-circuit cases.
        sc_txn(2, 8'h00, 8'h3A, 8'h3A);
        sc_txn(0, 8'h80, 8'h20, 8'h80);
        sc_txn(3, 8'h00, 8'h00, 8'h00);
        sc_txn(1, 8'h33, 8'h00, 8'h33);
        sc_txn(2, 8'h20, 8'h80, 8'h80);

        // All requesters valid continuously: strict rotation from pointer 0.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            ra[i] = 8'h00;
            rb[i] = 8'h10 + 8'(i);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 30 && glog.size() < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (req_ready[i]) glog.push_back(i);
            if (glog.size() < 5) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        chk("rr_count", glog.size(), 5);
        if (glog.size() == 5) begin
            chk("rr_g0", glog[0], 0);
            chk("rr_g1", glog[1], 1);
            chk("rr_g2", glog[2], 2);
            chk("rr_g3", glog[3], 3);
            chk("rr_g4", glog[4], 0);
        end
        repeat (2) @(posedge clk); #1;

        // Backpressure in RESP with another requester waiting.
        rsp_ready = 1'b0;
        ra[3] = 8'h48; rb[3] = 8'h38; dp_val = 8'h5C;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("stall_grant", req_ready, 4'b1000);
        @(posedge clk); #1;
        ra[0] = 8'h00; rb[0] = 8'h11;
        req_valid = 4'b0001;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk("stall_rsp_seen", seen, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_result", rsp_result, 8'h5C);
            chk("stall_id", rsp_id, 2'd3);
            chk("stall_req_ready", req_ready, 4'b0);
            @(negedge clk);
        end
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("after_accept_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("after_accept_result", rsp_result, 8'h11);
        chk("after_accept_id", rsp_id, 2'd0);
        @(posedge clk); #1;

        // Reset during ALIGN, then pointer must restart at 0.
        ra[0] = 8'h40; rb[0] = 8'h48; dp_val = 8'h4C;
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = (dp_stage_en == 5'b00010);
        end
        chk("align_seen", seen, 1'b1);
        #2;
        ra[0] = 8'h00; rb[0] = 8'h22;
        ra[2] = 8'h00; rb[2] = 8'h33;
        req_valid = 4'b0101;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stage", dp_stage_en, 5'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_ready", req_ready, 4'b0);
        chk("mid_rst_dp_a", dp_a, 8'h00);
        chk("mid_rst_dp_b", dp_b, 8'h00);
        chk("mid_rst_result", rsp_result, 8'h00);
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", req_ready, 4'b0001);
        @(negedge clk);
        chk("post_rst_valid", rsp_valid, 1'b1);
        chk("post_rst_result", rsp_result, 8'h22);
        chk("post_rst_id", rsp_id, 2'd0);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
